// File: rtl/writeback_port_arbiter.sv
// Writeback port arbiter: merges the pipeline write with late multicycle results
// buffered in a 2-entry FIFO, with conflict ordering and starvation-bounded drain.
module writeback_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [2:0]  pipe_dest,
    input  logic [15:0] pipe_data,
    input  logic        late_valid,
    input  logic [2:0]  late_dest,
    input  logic [15:0] late_data,
    output logic        late_ready,
    output logic        pipe_stall,
    output logic        regfile_load,
    output logic [2:0]  regfile_dest,
    output logic [15:0] regfile_data
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [2:0]    fifo_dest [2];
    logic [15:0]   fifo_data [2];
    logic [1:0]    count;
    logic          rd_ptr;
    logic          wr_ptr;
    logic [SW-1:0] starve;

    logic non_empty;
    logic full;
    logic conflict;
    logic drain;
    logic push;

    assign non_empty = (count != 2'd0);
    assign full      = (count == 2'd2);

    // Only entries already stored are compared; the one arriving this cycle is not yet visible.
    assign conflict = pipe_valid &&
                      ((non_empty && (fifo_dest[rd_ptr] == pipe_dest)) ||
                       (full && (fifo_dest[~rd_ptr] == pipe_dest)));

    assign drain = non_empty && (!pipe_valid || conflict || (starve == STARVE_MAX));

    assign late_ready = rst_n && !full;
    assign push       = late_valid && late_ready;
    assign pipe_stall = rst_n && pipe_valid && drain;

    always_comb begin
        regfile_load = 1'b0;
        regfile_dest = 3'd0;
        regfile_data = 16'd0;
        if (rst_n) begin
            if (drain) begin
                regfile_load = 1'b1;
                regfile_dest = fifo_dest[rd_ptr];
                regfile_data = fifo_data[rd_ptr];
            end else if (pipe_valid) begin
                regfile_load = 1'b1;
                regfile_dest = pipe_dest;
                regfile_data = pipe_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            fifo_dest[0] <= 3'd0;
            fifo_dest[1] <= 3'd0;
            fifo_data[0] <= 16'd0;
            fifo_data[1] <= 16'd0;
        end else begin
            if (push) begin
                fifo_dest[wr_ptr] <= late_dest;
                fifo_data[wr_ptr] <= late_data;
                wr_ptr            <= ~wr_ptr;
            end
            if (drain) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, drain};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (!non_empty || drain) begin
            starve <= '0;
        end else if (pipe_valid && (starve != STARVE_MAX)) begin
            starve <= starve + 1'b1;
        end
    end

endmodule

// File: doc/writeback_port_arbiter.md
WRITEBACK_PORT_ARBITER -- requirements
Module: writeback_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, meaning consecutive pipeline wins allowed while the late buffer is non-empty before a forced drain.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: pipe_valid  input  1  writeback stage has a register write this cycle.
REQ-005 Port: pipe_dest  input  3  destination register of the pipeline write.
REQ-006 Port: pipe_data  input  16  writeback mux result.
REQ-007 Port: late_valid  input  1  multicycle unit offers a result.
REQ-008 Port: late_dest  input  3  destination register of the late result.
REQ-009 Port: late_data  input  16  late result value.
REQ-010 Port: late_ready  output  1  buffer accepts a late result this cycle.
REQ-011 Port: pipe_stall  output  1  pipeline write refused this cycle; upstream holds pipe_valid/dest/data unchanged next cycle.
REQ-012 Port: regfile_load  output  1  register file write enable.
REQ-013 Port: regfile_dest  output  3  register file write address.
REQ-014 Port: regfile_data  output  16  register file write data.

Function
REQ-015 Late results SHALL pass through a 2-entry FIFO (entries: dest, data); a push occurs on the clk edge when late_valid and late_ready are both 1.
REQ-016 late_ready SHALL equal (FIFO count < 2), independent of the drain in the same cycle.
REQ-017 Conflict SHALL be 1 when pipe_valid=1 and pipe_dest equals dest of any stored valid FIFO entry; an entry being pushed this cycle is not compared.
REQ-018 Drain SHALL be 1 when FIFO non-empty and (pipe_valid=0, conflict=1, or starve count = STARVE_LIMIT).
REQ-019 On drain: regfile_load=1, dest/data = FIFO head; head popped at the edge.
REQ-020 Pipeline path: when pipe_valid=1 and drain=0, regfile_load=1, dest/data = pipe_dest/pipe_data, same-cycle (zero latency).
REQ-021 pipe_stall SHALL be 1 exactly when pipe_valid=1 and drain=1; otherwise 0.
REQ-022 When neither path writes, regfile_load=0 and regfile_dest/regfile_data=0.
REQ-023 Push and pop in the same cycle SHALL both occur; count unchanged; new entry behind the remaining entry; order strictly FIFO.
REQ-024 Starve counter (width to hold STARVE_LIMIT): increments, saturating at STARVE_LIMIT, each cycle the pipeline writes while FIFO non-empty; clears to 0 on any drain or when FIFO empty.
REQ-025 A late result pushed in cycle N is writable no earlier than cycle N+1.
REQ-026 A buffered conflict SHALL repeat the stall each cycle until no stored entry matches pipe_dest (up to 2 consecutive drains).

Reset
REQ-027 rst_n=0 SHALL asynchronously clear FIFO count, pointers and starve counter to 0.
REQ-028 While rst_n=0: late_ready=0, pipe_stall=0, regfile_load=0, regfile_dest=0, regfile_data=0, regardless of inputs.
REQ-029 Reset asserted mid-operation SHALL discard buffered entries with no register write; after release, late_ready=1 in the first cycle.

Verification
REQ-030 Idle drain: pipe_valid=0, push late (R3, 0x1234) -> next cycle regfile_load=1, dest=3, data=0x1234, FIFO empty after.
REQ-031 Pipeline priority: FIFO holds (R2, 0xAAAA), pipe_valid=1 dest R5 data 0x0055 -> regfile writes R5/0x0055, pipe_stall=0, starve count 1.
REQ-032 Starvation: FIFO holds one entry, pipe_valid=1 non-conflicting for 5 cycles -> cycles 1-4 pipeline writes, cycle 5 drains head with pipe_stall=1, cycle 6 pipeline write of held value.
REQ-033 Conflict ordering: FIFO holds (R1, 0x0001),(R1, 0x0002), pipe writes R1/0x0003 -> two stall cycles writing 0x0001 then 0x0002, then 0x0003; R1 final value 0x0003.
REQ-034 Full and simultaneous: FIFO full -> late_ready=0 and late_valid ignored; with count 1, push and drain same cycle -> count stays 1, new entry written next.
REQ-035 Reset mid-operation: FIFO holding 2 entries, rst_n low for one cycle -> all outputs 0 during reset, no subsequent write of old entries, late_ready=1 after release.
